// File: rtl/if_id_skid.sv
// IF/ID pipeline stage: valid/ready on both sides with a two-entry (main + skid) buffer,
// flush-to-NOP semantics and a saturating count of beats discarded by flush.
module if_id_skid #(
  parameter int unsigned        INSTR_W   = 32,
  parameter int unsigned        PC_W      = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = {INSTR_W{1'b0}},
  parameter int unsigned        CNT_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic               out_noflush,
  output logic [CNT_W-1:0]   drop_cnt
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e             state_q;
  logic [INSTR_W-1:0] main_instr_q, skid_instr_q;
  logic [PC_W-1:0]    main_pc_q, skid_pc_q;
  logic               noflush_q;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic               acc, con;
  logic [1:0]         held, delta;
  logic [CNT_W+1:0]   drop_sum;

  // Handshake outputs depend on state (and reset) only, never on in_valid/out_ready.
  always_comb begin
    in_ready  = (state_q != StTwo) & ~reset;
    out_valid = (state_q != StEmpty);
    acc       = in_valid & in_ready;
    con       = out_valid & out_ready;
    unique case (state_q)
      StEmpty: held = 2'd0;
      StOne:   held = 2'd1;
      StTwo:   held = 2'd2;
      default: held = 2'd0;
    endcase
  end

  // con implies at least one entry held and acc is impossible in StTwo, so delta is 0..2.
  always_comb begin
    delta    = held + {1'b0, acc} - {1'b0, con};
    drop_sum = {2'b00, drop_cnt_q} + {{CNT_W{1'b0}}, delta};
    if (drop_sum > {2'b00, {CNT_W{1'b1}}}) begin
      drop_cnt_d = {CNT_W{1'b1}};
    end else begin
      drop_cnt_d = drop_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StEmpty;
      main_instr_q <= NOP_INSTR;
      main_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
      noflush_q    <= 1'b0;
      drop_cnt_q   <= '0;
    end else if (flush) begin
      state_q      <= StEmpty;
      main_instr_q <= NOP_INSTR;
      main_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
      noflush_q    <= 1'b0;
      drop_cnt_q   <= drop_cnt_d;
    end else begin
      if (acc) begin
        noflush_q <= 1'b1;
      end
      unique case (state_q)
        StEmpty: begin
          if (acc) begin
            state_q      <= StOne;
            main_instr_q <= in_instr;
            main_pc_q    <= in_pc;
          end
        end
        StOne: begin
          if (acc && !con) begin
            state_q      <= StTwo;
            skid_instr_q <= in_instr;
            skid_pc_q    <= in_pc;
          end else if (acc && con) begin
            main_instr_q <= in_instr;
            main_pc_q    <= in_pc;
          end else if (con) begin
            // Main keeps its last value when draining.
            state_q <= StEmpty;
          end
        end
        StTwo: begin
          if (con) begin
            state_q      <= StOne;
            main_instr_q <= skid_instr_q;
            main_pc_q    <= skid_pc_q;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

  assign out_instr   = main_instr_q;
  assign out_pc      = main_pc_q;
  assign out_noflush = noflush_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_if_id_skid.sv
// Bench for if_id_skid: directed vector table plus random traffic against a queue model.
module tb_if_id_skid;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush, out_ready;
  logic [31:0] in_instr, in_pc;
  logic        in_ready, out_valid, out_noflush;
  logic [31:0] out_instr, out_pc;
  logic [7:0]  drop_cnt;
  logic        in_ready2, out_valid2, out_noflush2;
  logic [31:0] out_instr2, out_pc2;
  logic [1:0]  drop_cnt2;

  always #5 clk = ~clk;

  if_id_skid dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_noflush(out_noflush), .drop_cnt(drop_cnt)
  );

  if_id_skid #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid2),
    .out_ready(out_ready), .out_instr(out_instr2), .out_pc(out_pc2),
    .out_noflush(out_noflush2), .drop_cnt(drop_cnt2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of beats plus the value the main register shows when empty.
  typedef struct packed {logic [31:0] instr; logic [31:0] pc;} beat_t;
  beat_t       mq[$];
  logic [31:0] m_last_instr = '0;
  logic [31:0] m_last_pc    = '0;
  bit          m_noflush    = 0;
  int          m_drop       = 0;

  task automatic model_step();
    int    n   = mq.size();
    bit    acc = in_valid && n < 2 && !reset;
    bit    con = n > 0 && out_ready;
    beat_t b;
    if (reset) begin
      mq.delete();
      m_last_instr = '0; m_last_pc = '0; m_noflush = 0; m_drop = 0;
    end else if (flush) begin
      m_drop += n + int'(acc) - int'(con);
      mq.delete();
      m_last_instr = '0; m_last_pc = '0; m_noflush = 0;
    end else begin
      if (con) begin
        b = mq.pop_front();
        m_last_instr = b.instr; m_last_pc = b.pc;
      end
      if (acc) begin
        mq.push_back({in_instr, in_pc});
        m_noflush = 1;
      end
    end
  endtask

  task automatic model_check();
    bit          ev = mq.size() > 0;
    logic [31:0] ei = ev ? mq[0].instr : m_last_instr;
    logic [31:0] ep = ev ? mq[0].pc : m_last_pc;
    chk("m_out_valid", 64'(out_valid), 64'(ev));
    chk("m_in_ready", 64'(in_ready), 64'(mq.size() < 2 && !reset));
    if (ev || !reset) begin
      chk("m_out_instr", 64'(out_instr), 64'(ei));
      chk("m_out_pc", 64'(out_pc), 64'(ep));
    end
    chk("m_out_noflush", 64'(out_noflush), 64'(m_noflush));
    chk("m_drop_cnt", 64'(drop_cnt), 64'(m_drop > 255 ? 255 : m_drop));
    chk("m_drop_cnt2", 64'(drop_cnt2), 64'(m_drop > 3 ? 3 : m_drop));
    chk("m_dut2_out", {out_valid2, out_instr2[30:0], out_pc2}, {ev, ei[30:0], ep});
  endtask

  typedef struct {
    bit rst; bit iv; logic [31:0] instr; logic [31:0] pc; bit fl; bit ordy;
    bit ov; bit ir; logic [31:0] ei; logic [31:0] ep; bit enf; int ed;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit rst, input bit iv, input logic [31:0] instr,
                     input logic [31:0] pc, input bit fl, input bit ordy, input bit ov,
                     input bit ir, input logic [31:0] ei, input logic [31:0] ep,
                     input bit enf, input int ed);
    vec_t v;
    v.rst = rst; v.iv = iv; v.instr = instr; v.pc = pc; v.fl = fl; v.ordy = ordy;
    v.ov = ov; v.ir = ir; v.ei = ei; v.ep = ep; v.enf = enf; v.ed = ed;
    tbl.push_back(v);
  endtask

  task automatic drive(input bit rst, input bit iv, input logic [31:0] instr,
                       input logic [31:0] pc, input bit fl, input bit ordy);
    reset = rst; in_valid = iv; in_instr = instr; in_pc = pc; flush = fl; out_ready = ordy;
  endtask

  initial begin
    // Expected columns are outputs seen during the cycle the row's inputs are applied.
    //  rst iv instr        pc     fl rdy  ov ir out_instr    out_pc  nf drop
    add(1, 0, 32'h0,        32'h0,  0, 0,  0, 0, 32'h0,        32'h0,  0, 0);
    add(0, 1, 32'h00000013, 32'h0,  0, 1,  0, 1, 32'h0,        32'h0,  0, 0);
    add(0, 1, 32'h00100093, 32'h4,  0, 1,  1, 1, 32'h00000013, 32'h0,  1, 0);
    add(0, 0, 32'h0,        32'h0,  0, 1,  1, 1, 32'h00100093, 32'h4,  1, 0);
    add(0, 1, 32'hA,        32'h8,  0, 0,  0, 1, 32'h00100093, 32'h4,  1, 0);
    add(0, 1, 32'hB,        32'hC,  0, 0,  1, 1, 32'hA,        32'h8,  1, 0);
    add(0, 1, 32'hC0,       32'h10, 0, 0,  1, 0, 32'hA,        32'h8,  1, 0);
    add(0, 1, 32'hC0,       32'h10, 0, 1,  1, 0, 32'hA,        32'h8,  1, 0);
    add(0, 1, 32'hC0,       32'h10, 0, 1,  1, 1, 32'hB,        32'hC,  1, 0);
    add(0, 0, 32'h0,        32'h0,  0, 1,  1, 1, 32'hC0,       32'h10, 1, 0);
    add(0, 0, 32'h0,        32'h0,  0, 0,  0, 1, 32'hC0,       32'h10, 1, 0);
    add(0, 1, 32'hD,        32'h14, 0, 0,  0, 1, 32'hC0,       32'h10, 1, 0);
    add(0, 1, 32'hE,        32'h18, 0, 0,  1, 1, 32'hD,        32'h14, 1, 0);
    add(0, 0, 32'h0,        32'h0,  1, 0,  1, 0, 32'hD,        32'h14, 1, 0);
    add(0, 0, 32'h0,        32'h0,  0, 0,  0, 1, 32'h0,        32'h0,  0, 2);
    add(0, 1, 32'hF,        32'h1C, 0, 0,  0, 1, 32'h0,        32'h0,  0, 2);
    add(0, 1, 32'h10,       32'h20, 1, 0,  1, 1, 32'hF,        32'h1C, 1, 2);
    add(0, 1, 32'h11,       32'h24, 0, 0,  0, 1, 32'h0,        32'h0,  0, 4);
    add(0, 0, 32'h0,        32'h0,  0, 0,  1, 1, 32'h11,       32'h24, 1, 4);
    add(0, 1, 32'h12,       32'h28, 0, 0,  1, 1, 32'h11,       32'h24, 1, 4);
    add(1, 1, 32'h13,       32'h2C, 0, 0,  1, 0, 32'h11,       32'h24, 1, 4);
    add(0, 0, 32'h0,        32'h0,  0, 0,  0, 1, 32'h0,        32'h0,  0, 0);
    add(0, 1, 32'h14,       32'h30, 1, 0,  0, 1, 32'h0,        32'h0,  0, 0);
    add(0, 1, 32'h15,       32'h34, 1, 0,  0, 1, 32'h0,        32'h0,  0, 1);
    add(0, 1, 32'h16,       32'h38, 1, 0,  0, 1, 32'h0,        32'h0,  0, 2);
    add(0, 1, 32'h17,       32'h3C, 1, 0,  0, 1, 32'h0,        32'h0,  0, 3);
    add(0, 0, 32'h0,        32'h0,  0, 0,  0, 1, 32'h0,        32'h0,  0, 4);

    drive(1, 0, '0, '0, 0, 0);
    repeat (2) begin
      model_step();
      @(posedge clk); #1;
    end

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].iv, tbl[i].instr, tbl[i].pc, tbl[i].fl, tbl[i].ordy);
      #1;
      chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].ov));
      chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].ir));
      chk($sformatf("v%0d_out_instr", i), 64'(out_instr), 64'(tbl[i].ei));
      chk($sformatf("v%0d_out_pc", i), 64'(out_pc), 64'(tbl[i].ep));
      chk($sformatf("v%0d_out_noflush", i), 64'(out_noflush), 64'(tbl[i].enf));
      chk($sformatf("v%0d_drop_cnt", i), 64'(drop_cnt), 64'(tbl[i].ed));
      chk($sformatf("v%0d_drop_cnt2", i), 64'(drop_cnt2), 64'(tbl[i].ed > 3 ? 3 : tbl[i].ed));
      model_step();
      @(posedge clk); #1;
    end

    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(99) < 2, $urandom_range(99) < 60, $urandom, $urandom,
            $urandom_range(99) < 6, $urandom_range(99) < 55);
      #1;
      model_check();
      model_step();
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
